pixel_phase_gen: RTL



---
 rtl/pixel_phase_gen.sv | 76 +++++++
 1 files changed

// File: rtl/pixel_phase_gen.sv
// pixel_phase_gen: lock-qualified downstream reset plus a sync_in-realigned 1-in-DIVIDER pixel strobe.
// Defining PIXEL_PHASE_ERR_CNT_EN adds err_clr/err_cnt, a saturating count of realign pulses.
module pixel_phase_gen #(
  parameter int DIVIDER            = 8,
  parameter int PIX_PHASE          = 4,
  parameter int LOCK_STABLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sync_in,
`ifdef PIXEL_PHASE_ERR_CNT_EN
  input  logic       err_clr,
  output logic [7:0] err_cnt,
`endif
  output logic       reset_out_n,
  output logic       pix_en,
  output logic [3:0] phase,
  output logic       realign
);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES);
  typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, RUN} state_t;
  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_stab_cnt, w_stab_nxt;
  logic [1:0]    r_lk;
  logic [2:0]    r_sy;
  logic [3:0]    r_phase, w_phase_nxt;
  logic          r_rst_out, r_pix, r_realign;
  logic          w_locked, w_edge, w_run, w_pix_nxt, w_realign_nxt;
  assign w_locked = r_lk[1];
  assign w_edge   = r_sy[1] & ~r_sy[2];
  // Lock loss in RUN overrides edge handling and the phase update on the same clock.
  assign w_run    = (r_state == RUN) & w_locked;
  always_comb begin
    w_state_nxt   = !w_locked ? WAIT_LOCK :
                    (r_state == RUN || (r_state == STABILIZE && r_stab_cnt == SW'(LOCK_STABLE_CYCLES - 1))) ? RUN : STABILIZE;
    w_stab_nxt    = (r_state == STABILIZE && w_state_nxt == STABILIZE) ? r_stab_cnt + 1'b1 : '0;
    w_phase_nxt   = !w_run ? 4'd0 : w_edge ? 4'd1 : (r_phase == 4'(DIVIDER - 1)) ? 4'd0 : r_phase + 4'd1;
    w_realign_nxt = w_run & w_edge & (r_phase != 4'd0);
    w_pix_nxt     = w_run & (w_edge ? (PIX_PHASE == 0) : (r_phase == 4'(PIX_PHASE)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lk       <= '0;
      r_sy       <= '0;
      r_state    <= WAIT_LOCK;
      r_stab_cnt <= '0;
      r_rst_out  <= 1'b0;
      r_phase    <= '0;
      r_pix      <= 1'b0;
      r_realign  <= 1'b0;
    end else begin
      r_lk       <= {r_lk[0], pll_locked};
      r_sy       <= {r_sy[1:0], sync_in};
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_rst_out  <= w_run;
      r_phase    <= w_phase_nxt;
      r_pix      <= w_pix_nxt;
      r_realign  <= w_realign_nxt;
    end
  end
  assign reset_out_n = r_rst_out;
  assign pix_en      = r_pix;
  assign phase       = r_phase;
  assign realign     = r_realign;
`ifdef PIXEL_PHASE_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_cnt <= '0;
    else if (err_clr) r_err_cnt <= '0;
    else if (r_realign && r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`endif
endmodule
